// File: rtl/kb_scan_history_if.sv
// Keyboard-side handshake plus history/counter outputs of kb_scan_history.
// master = keyboard/stimulus side, slave = the history block.
interface kb_scan_history_if #(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 8
);
  logic [7:0]         scan_code;
  logic               scan_code_ready;
  logic               make_only;
  logic               freeze;
  logic               clear;
  logic [8*DEPTH-1:0] history;
  logic [DEPTH-1:0]   hist_valid;
  logic [COUNT_W-1:0] press_count;
  logic               new_entry;
  logic               held_valid;

  modport master (
    output scan_code, scan_code_ready, make_only, freeze, clear,
    input  history, hist_valid, press_count, new_entry, held_valid
  );

  modport slave (
    input  scan_code, scan_code_ready, make_only, freeze, clear,
    output history, hist_valid, press_count, new_entry, held_valid
  );
endinterface

// File: rtl/kb_scan_history.sv
// Scan-code history: newest-first shift register of accepted bytes, with an
// optional make-only filter (drops E0 prefixes, F0 breaks, typematic repeats)
// and a saturating count of accepted bytes.

// One history entry: loads from its neighbour (or the new byte) on a push.
module kb_hist_cell (
  input  logic       clk,
  input  logic       srst,
  input  logic       shift,
  input  logic [7:0] d,
  input  logic       vld_d,
  output logic [7:0] q,
  output logic       vld
);
  // entry register, cleared by reset/clear
  always_ff @(posedge clk) begin
    if (srst) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (shift) begin
      q   <= d;
      vld <= vld_d;
    end
  end
endmodule

module kb_scan_history #(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  kb_scan_history_if.slave bus
);
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK} state_t;

  state_t                  state_q, state_n;
  logic                    srst;
  logic                    rdy_q;
  logic                    ev;
  logic                    accept, push, hold_set, hold_clr;
  logic                    held_valid_q;
  logic [7:0]              held_code_q;
  logic [COUNT_W-1:0]      cnt_q;
  logic [1:0]              vld_pipe;
  logic [DEPTH-1:0][7:0]   hist_q;
  logic [DEPTH-1:0]        hv_q;

  // clear behaves exactly like reset, so it also wins over a coincident event
  assign srst = reset | bus.clear;
  assign ev   = bus.scan_code_ready & ~rdy_q;
  // frozen accepts still count but never touch the visible history
  assign push        = accept & ~bus.freeze;
  assign vld_pipe[0] = push;

  // make-only filter decode; raw mode pins the FSM to IDLE and accepts all
  always_comb begin
    state_n  = state_q;
    accept   = 1'b0;
    hold_set = 1'b0;
    hold_clr = 1'b0;
    if (!bus.make_only) begin
      state_n = IDLE;
      accept  = ev;
    end else if (ev) begin
      case (state_q)
        IDLE, EXT: begin
          if (bus.scan_code == CODE_EXT) begin
            state_n = EXT;
          end else if (bus.scan_code == CODE_BRK) begin
            state_n = BRK;
          end else begin
            state_n = IDLE;
            // same code while still held is a typematic repeat
            if (!(held_valid_q && bus.scan_code == held_code_q)) begin
              accept   = 1'b1;
              hold_set = 1'b1;
            end
          end
        end
        BRK: begin
          state_n  = IDLE;
          hold_clr = (bus.scan_code == held_code_q);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM, edge detector, held-key tracking, counter and new_entry pulse
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= IDLE;
      rdy_q        <= 1'b0;
      held_valid_q <= 1'b0;
      held_code_q  <= '0;
      cnt_q        <= '0;
      vld_pipe[1]  <= 1'b0;
    end else begin
      state_q     <= state_n;
      rdy_q       <= bus.scan_code_ready;
      vld_pipe[1] <= vld_pipe[0];
      if (accept && cnt_q != '1)
        cnt_q <= cnt_q + COUNT_W'(1);
      if (!bus.make_only) begin
        held_valid_q <= 1'b0;
      end else if (hold_set) begin
        held_valid_q <= 1'b1;
        held_code_q  <= bus.scan_code;
      end else if (hold_clr) begin
        held_valid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    if (i == 0) begin : g_head
      kb_hist_cell u_cell (
        .clk   (clk),
        .srst  (srst),
        .shift (push),
        .d     (bus.scan_code),
        .vld_d (1'b1),
        .q     (hist_q[i]),
        .vld   (hv_q[i])
      );
    end else begin : g_tail
      kb_hist_cell u_cell (
        .clk   (clk),
        .srst  (srst),
        .shift (push),
        .d     (hist_q[i-1]),
        .vld_d (hv_q[i-1]),
        .q     (hist_q[i]),
        .vld   (hv_q[i])
      );
    end
  end

  assign bus.history     = hist_q;
  assign bus.hist_valid  = hv_q;
  assign bus.press_count = cnt_q;
  assign bus.new_entry   = vld_pipe[1];
  assign bus.held_valid  = held_valid_q;
endmodule

// File: tb/tb_kb_scan_history.sv
// Directed bench: two instances (8-bit and 2-bit counter) see identical
// stimulus; accepted bytes push expected snapshots into a queue that a
// negedge monitor pops whenever new_entry is seen.
module tb_kb_scan_history;
  logic clk = 1'b0;
  logic reset;

  always #10 clk = ~clk;

  kb_scan_history_if #(.DEPTH(4), .COUNT_W(8)) b1();
  kb_scan_history_if #(.DEPTH(4), .COUNT_W(2)) b2();

  assign b2.scan_code       = b1.scan_code;
  assign b2.scan_code_ready = b1.scan_code_ready;
  assign b2.make_only       = b1.make_only;
  assign b2.freeze          = b1.freeze;
  assign b2.clear           = b1.clear;

  kb_scan_history #(.DEPTH(4), .COUNT_W(8)) dut  (.clk(clk), .reset(reset), .bus(b1));
  kb_scan_history #(.DEPTH(4), .COUNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

  typedef struct {
    logic [31:0] hist;
    logic [3:0]  hv;
    int          cnt;
  } exp_t;

  exp_t            exp_q[$];
  int              n_pass = 0;
  int              n_tot  = 0;
  logic [3:0][7:0] m_hist;
  logic [3:0]      m_hv;
  int              m_cnt;
  bit              m_frz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int sat(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  task automatic model_reset();
    m_hist = '0;
    m_hv   = '0;
    m_cnt  = 0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    exp_t e;
    m_cnt++;
    if (!m_frz) begin
      m_hist = {m_hist[2:0], b};
      m_hv   = {m_hv[2:0], 1'b1};
      e.hist = m_hist;
      e.hv   = m_hv;
      e.cnt  = m_cnt;
      exp_q.push_back(e);
    end
  endtask

  // one ready pulse; held/count settle one cycle after the event
  task automatic send(input logic [7:0] b, input bit acc, input bit held_exp);
    @(negedge clk);
    b1.scan_code       = b;
    b1.scan_code_ready = 1'b1;
    if (acc) model_accept(b);
    @(negedge clk);
    b1.scan_code_ready = 1'b0;
    chk("held_valid", b1.held_valid, held_exp);
    chk("press_count", b1.press_count, m_cnt);
    chk("press_count_sat", b2.press_count, sat(m_cnt));
  endtask

  task automatic hold(input logic [7:0] b, input int n);
    @(negedge clk);
    b1.scan_code       = b;
    b1.scan_code_ready = 1'b1;
    model_accept(b);
    repeat (n - 1) @(negedge clk);
    b1.scan_code_ready = 1'b0;
    @(negedge clk);
    chk("hold_count", b1.press_count, m_cnt);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    b1.clear = 1'b1;
    @(negedge clk);
    b1.clear = 1'b0;
    model_reset();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_hist"}, b1.history, 32'h0);
    chk({name, "_hv"}, b1.hist_valid, 4'h0);
    chk({name, "_cnt"}, b1.press_count, 8'h0);
    chk({name, "_cnt2"}, b2.press_count, 2'h0);
    chk({name, "_new"}, b1.new_entry, 1'b0);
    chk({name, "_held"}, b1.held_valid, 1'b0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (b1.new_entry || b2.new_entry) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_new_entry", {b1.new_entry, b2.new_entry}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("sb_new_entry_pair", {b1.new_entry, b2.new_entry}, 2'b11);
        chk("sb_history", b1.history, e.hist);
        chk("sb_hist_valid", b1.hist_valid, e.hv);
        chk("sb_press_count", b1.press_count, e.cnt);
        chk("sb_history2", b2.history, e.hist);
        chk("sb_press_count2", b2.press_count, sat(e.cnt));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    b1.scan_code       = '0;
    b1.scan_code_ready = 1'b0;
    b1.make_only       = 1'b0;
    b1.freeze          = 1'b0;
    b1.clear           = 1'b0;
    m_frz              = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    // raw mode, four bytes then a fifth to push the oldest out
    send(8'h1C, 1, 0);
    send(8'h32, 1, 0);
    send(8'h21, 1, 0);
    send(8'h23, 1, 0);
    chk("t1_hist4", b1.history, 32'h1C322123);
    chk("t1_hv4", b1.hist_valid, 4'hF);
    send(8'h24, 1, 0);
    chk("t1_hist5", b1.history, 32'h32212324);
    chk("t1_cnt_sat", b2.press_count, 2'd3);

    // level held high is one event; a new rising edge is a second
    pulse_clear();
    hold(8'h1C, 10);
    chk("t2_cnt1", b1.press_count, 8'd1);
    hold(8'h1C, 3);
    chk("t2_cnt2", b1.press_count, 8'd2);

    // make-only: repeats dropped, break releases, re-press logs again
    pulse_clear();
    b1.make_only = 1'b1;
    send(8'h1C, 1, 1);
    send(8'h1C, 0, 1);
    send(8'h1C, 0, 1);
    send(8'hF0, 0, 1);
    send(8'h1C, 0, 0);
    send(8'h1C, 1, 1);
    chk("t3_hist", b1.history, 32'h00001C1C);
    chk("t3_hv", b1.hist_valid, 4'h3);
    chk("t3_cnt", b1.press_count, 8'd2);

    // extended key make/break
    send(8'hE0, 0, 1);
    send(8'h75, 1, 1);
    send(8'hE0, 0, 1);
    send(8'hF0, 0, 1);
    send(8'h75, 0, 0);
    chk("t4_hist", b1.history, 32'h001C1C75);
    chk("t4_cnt", b1.press_count, 8'd3);

    // back to raw: held clears
    @(negedge clk);
    b1.make_only = 1'b0;
    @(negedge clk);
    chk("raw_held_clr", b1.held_valid, 1'b0);

    // freeze: counter runs, history and new_entry held
    b1.freeze = 1'b1;
    m_frz     = 1'b1;
    send(8'h1C, 1, 0);
    send(8'h32, 1, 0);
    chk("t5_frz_hist", b1.history, 32'h001C1C75);
    chk("t5_frz_cnt", b1.press_count, 8'd5);
    @(negedge clk);
    b1.freeze = 1'b0;
    m_frz     = 1'b0;
    send(8'h21, 1, 0);
    chk("t5_hist", b1.history, 32'h1C1C7521);
    chk("t5_hv", b1.hist_valid, 4'hF);

    // clear coincident with an event: byte lost
    @(negedge clk);
    b1.clear           = 1'b1;
    b1.scan_code       = 8'h55;
    b1.scan_code_ready = 1'b1;
    @(negedge clk);
    b1.clear           = 1'b0;
    b1.scan_code_ready = 1'b0;
    model_reset();
    chk_zero("clr_ev");
    @(negedge clk);
    chk("clr_ev_late_hist", b1.history, 32'h0);

    // reset while in BRK: next byte is a make again
    b1.make_only = 1'b1;
    send(8'h1C, 1, 1);
    send(8'hF0, 0, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_zero("rst_brk");
    send(8'h1C, 1, 1);
    chk("t6_hist", b1.history, 32'h0000001C);
    chk("t6_hv", b1.hist_valid, 4'h1);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
